// File: rtl/sine_meas_pkg.sv
// Shared types and defaults for the sine frequency measurement block and its divider.
// The divider width covers num = 2^(PHASE_W+NCYC_LOG2), one bit wider than the exponent.
package sine_meas_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DIV,
      ST_DONE
   } meas_state_t;

   localparam int DEF_PHASE_W   = 16;
   localparam int DEF_NCYC_LOG2 = 2;
   localparam int DEF_HYST      = 64;
   localparam int DEF_CNT_W     = 24;
   localparam int DEF_TMO_SMP   = 1048576;
   localparam int DEF_DATA_W    = 12;

   function automatic int div_width(input int phase_w, input int ncyc_log2);
      return phase_w + ncyc_log2 + 1;
   endfunction

endpackage

// File: rtl/sine_freq_meas_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// quot is valid while done is high and holds until the next start.
module seq_divider_u
   import sine_meas_pkg::*;
#(
   parameter int N_W = div_width(DEF_PHASE_W, DEF_NCYC_LOG2),
   parameter int D_W = DEF_CNT_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N_W-1:0] num,
   input  logic [D_W-1:0] den,
   output logic           busy,
   output logic           done,
   output logic [N_W-1:0] quot
);

   localparam int C_W = $clog2(N_W + 1);

   logic [C_W-1:0] step_cnt;
   logic [D_W-1:0] den_r;
   logic [D_W-1:0] rem;
   logic [D_W:0]   rem_sh;
   logic [D_W:0]   diff;
   logic           ge;

   // quot doubles as the numerator shift register: dividend bits leave at the MSB
   always_comb begin
      rem_sh = {rem, quot[N_W-1]};
      diff   = rem_sh - {1'b0, den_r};
      ge     = (rem_sh >= {1'b0, den_r});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         step_cnt <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            busy     <= 1'b1;
            step_cnt <= C_W'(N_W);
         end else if (busy) begin
            step_cnt <= step_cnt - 1'b1;
            if (step_cnt == C_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start && !busy) begin
         rem   <= '0;
         quot  <= num;
         den_r <= den;
      end else if (busy) begin
         rem  <= ge ? diff[D_W-1:0] : rem_sh[D_W-1:0];
         quot <= {quot[N_W-2:0], ge};
      end
   end

endmodule

// File: rtl/sine_freq_meas.sv
// Estimates the sine_gen f_set word of a sampled sinusoid from the sample span of
// 2^NCYC_LOG2 periods, delimited by hysteretic rising zero crossings.
module sine_freq_meas
   import sine_meas_pkg::*;
#(
   parameter int PHASE_W   = DEF_PHASE_W,
   parameter int NCYC_LOG2 = DEF_NCYC_LOG2,
   parameter int HYST      = DEF_HYST,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int TMO_SMP   = DEF_TMO_SMP,
   parameter int DATA_W    = DEF_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pls,
   input  logic signed [DATA_W-1:0] din,
   output logic [PHASE_W-1:0]       f_est,
   output logic [CNT_W-1:0]         span,
   output logic                     meas_dn,
   output logic                     lock,
   output logic                     timeout
);

   localparam int DIV_W = div_width(PHASE_W, NCYC_LOG2);
   localparam int XC_W  = NCYC_LOG2 + 1;
   localparam logic [XC_W-1:0]          XC_LAST  = XC_W'((1 << NCYC_LOG2) - 1);
   localparam logic [CNT_W-1:0]         TMO_LAST = CNT_W'(TMO_SMP - 1);
   localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
   localparam logic signed [DATA_W-1:0] HYST_NEG = DATA_W'(-HYST);
   localparam logic [DIV_W-1:0]         DIV_NUM  = {1'b1, {(DIV_W-1){1'b0}}};

   meas_state_t       state;
   logic [CNT_W-1:0]  smp_cnt;
   logic [CNT_W-1:0]  smp_inc;
   logic [XC_W-1:0]   xcnt;
   logic [CNT_W-1:0]  den;
   logic              armed;
   logic              xing;
   logic              tmo_hit;
   logic              win_end;
   logic              div_start;
   logic              div_busy;
   logic              div_done;
   logic [DIV_W-1:0]  div_quot;

   function automatic logic [PHASE_W-1:0] sat_f(input logic [DIV_W-1:0] q);
      if (q[DIV_W-1:PHASE_W] != '0)
         return '1;
      return q[PHASE_W-1:0];
   endfunction

   always_comb begin
      xing    = pls && armed && (din >= HYST_POS);
      tmo_hit = pls && ((state == ST_IDLE) || (state == ST_COUNT)) && (smp_cnt == TMO_LAST);
      smp_inc = (smp_cnt == '1) ? smp_cnt : smp_cnt + 1'b1;
      win_end = (state == ST_COUNT) && !tmo_hit && xing && (xcnt == XC_LAST) && !div_busy;
   end

   // the completing crossing sample is part of the span, hence smp_cnt+1
   always_ff @(posedge clk) begin
      if (win_end)
         den <= smp_inc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         smp_cnt   <= '0;
         xcnt      <= '0;
         armed     <= 1'b0;
         div_start <= 1'b0;
         f_est     <= '0;
         span      <= '0;
         meas_dn   <= 1'b0;
         lock      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         meas_dn   <= 1'b0;
         timeout   <= 1'b0;
         div_start <= 1'b0;
         if (pls) begin
            if (xing)
               armed <= 1'b0;
            else if (din <= HYST_NEG)
               armed <= 1'b1;
         end
         // timeout overrides a crossing on the same sample
         if (tmo_hit) begin
            timeout <= 1'b1;
            lock    <= 1'b0;
            smp_cnt <= '0;
            xcnt    <= '0;
            armed   <= 1'b0;
            state   <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (xing) begin
                     smp_cnt <= '0;
                     xcnt    <= '0;
                     state   <= ST_COUNT;
                  end else if (pls) begin
                     smp_cnt <= smp_inc;
                  end
               end
               ST_COUNT: begin
                  if (win_end) begin
                     smp_cnt   <= '0;
                     xcnt      <= '0;
                     div_start <= 1'b1;
                     state     <= ST_DIV;
                  end else if (pls) begin
                     smp_cnt <= smp_inc;
                     if (xing)
                        xcnt <= xcnt + 1'b1;
                  end
               end
               ST_DIV: begin
                  if (pls) begin
                     smp_cnt <= smp_inc;
                     if (xing && (xcnt != XC_LAST))
                        xcnt <= xcnt + 1'b1;
                  end
                  if (div_done) begin
                     f_est   <= sat_f(div_quot);
                     span    <= den;
                     meas_dn <= 1'b1;
                     lock    <= 1'b1;
                     state   <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  if (pls) begin
                     smp_cnt <= smp_inc;
                     if (xing && (xcnt != XC_LAST))
                        xcnt <= xcnt + 1'b1;
                  end
                  state <= ST_COUNT;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   seq_divider_u #(
      .N_W (DIV_W),
      .D_W (CNT_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .num   (DIV_NUM),
      .den   (den),
      .busy  (div_busy),
      .done  (div_done),
      .quot  (div_quot)
   );

endmodule

// File: doc/sine_freq_meas.md
Name: sine_freq_meas

Overview:
- Receive-side counterpart of sine_gen: estimates the f_set value that produced a sampled 12-bit signed sinusoid.
- Measures the pls samples spanned by 2^NCYC_LOG2 full periods using hysteretic rising zero crossings.
- Converts that span to an f_set-compatible word with a sequential divider.
- Used on the carrier or demodulated path of the AM chain to close the loop against f_carrier / f_source.

Parameters:
- PHASE_W, 16, phase-accumulator width of sine_gen; f_set = 2^PHASE_W / period_in_samples.
- NCYC_LOG2, 2, log2 of periods averaged per measurement (NCYC = 4).
- HYST, 64, hysteresis threshold in signed LSBs (arm at din <= -HYST, fire at din >= +HYST).
- CNT_W, 24, sample-counter width.
- TMO_SMP, 1048576, samples without a completed window before timeout.

Ports:
- clk  in  1  system clock, 125 MHz
- rst  in  1  asynchronous, active-low reset
- pls  in  1  sample strobe, 1 clk wide, 500 kHz; din valid when pls=1
- din  in  12  signed two's-complement sample
- f_est  out  16  estimated f_set, truncated, saturated to 0xFFFF
- span  out  CNT_W  latched sample count of last window
- meas_dn  out  1  1-clk pulse when f_est/span update
- lock  out  1  high after first valid measurement until timeout/reset
- timeout  out  1  1-clk pulse on timeout

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM in IDLE; counters cleared; crossing detector disarmed.
- Everything except the divider advances only on clk edges where pls=1. The divider advances every clk.
- Crossing detector:
  - armed <= 1 when din <= -HYST.
  - A crossing fires on a sample with armed=1 and din >= +HYST; armed clears in the same cycle.
  - At most one crossing per sample.
- smp_cnt: increments on every pls; saturates at 2^CNT_W-1.
- xcnt: counts crossings within the window.
- FSM:
  - IDLE: wait for a crossing. On a crossing, set smp_cnt <= 0 and xcnt <= 0, then go to COUNT.
  - COUNT: each pls sets smp_cnt += 1. On a crossing, xcnt += 1. When xcnt reaches NCYC, latch den = smp_cnt+1 (count includes the crossing sample), restart smp_cnt <= 0 and xcnt <= 0 for the next window (this crossing starts it), then go to DIV.
  - DIV:
    - Restoring divide of num = 2^(PHASE_W+NCYC_LOG2) by den, 1 quotient bit per clk, PHASE_W+NCYC_LOG2+1 clks.
    - Sample counting/crossing detection for the next window continues on pls during DIV.
    - At 250 clk per pls, DIV always completes before the next pls.
    - Then go to DONE.
  - DONE (1 clk): f_est <= quotient, saturated to 0xFFFF if it exceeds 16 bits; span <= den; meas_dn=1; lock <= 1; then go to COUNT.
- Timeout:
  - In IDLE or COUNT, if smp_cnt reaches TMO_SMP: timeout=1 for 1 clk, lock <= 0, f_est unchanged, clear the counters and armed, go to IDLE.
- Simultaneous events:
  - A crossing on the same sample as a timeout: the timeout wins.
  - A pls coinciding with DONE is counted normally.
- Latency: meas_dn follows the completing crossing sample by PHASE_W+NCYC_LOG2+3 clk (21 clk at defaults).
- den is never 0: the minimum legal span is 2*NCYC samples.

Decomposition:
- Package sine_meas_pkg:
  - FSM state encoding (IDLE, COUNT, DIV, DONE).
  - Default parameter constants.
  - Divider width function PHASE_W+NCYC_LOG2+1.
- Sub-module seq_divider_u: start/busy/done handshake; unsigned numerator and denominator; quotient out. Reusable by demod_am_top index calculation.

Test Plan:
- sine_gen with f_set=1024 (64-sample period), amplitude ±2000 -> first meas_dn after about 5 periods; span=256, f_est=1024, lock=1. Steady state: one meas_dn every 256 pls.
- Ideal sine with a 100-sample period -> span=400, f_est=655 (65536*4/400 truncated); stays stable over 10 windows.
- Noisy sine, period 64, ±40 LSB noise added near zero (inside HYST) -> no double crossings; f_est=1024 ±1.
- din held at 0 after lock -> timeout pulse exactly TMO_SMP pls after the last window start; lock=0; f_est holds the last value; no meas_dn.
- rst asserted mid-DIV, then released -> all outputs 0 immediately on assert. The next valid meas_dn requires a fresh IDLE crossing plus NCYC periods.
- Frequency step from f_set=1024 to 2048 mid-window -> the transitional window gives an intermediate f_est; the following window gives f_est=2048, span=128.
